videocard_loader: RTL and testbench
===================================

VIDEOCARD_LOADER -- requirements
Module: videocard_loader

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data word width; BYTES, default 4, byte lanes per word; TIMEOUT, default 1048576, number of poll cycles before abort.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 reset_sink_reset_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  one-cycle request that begins a job; ignored while busy.
REQ-005 base_addr  in  WIDTH/2  first RAM word address; latched on start.
REQ-006 word_count  in  WIDTH/2  number of words to load; latched on start; 0 means skip the load phase.
REQ-007 src_data  in  WIDTH; src_valid  in  1; src_ready  out  1  valid/ready input stream of words to load.
REQ-008 address  out  WIDTH/2; data_out  out  WIDTH; byteenable  out  BYTES; write  out  1  RAM-port master, one word per write cycle, no wait states.
REQ-009 address_control  out  1; data_in_control  out  WIDTH; write_control  out  1; read_control  out  1; data_out_control  in  WIDTH  control-port master.
REQ-010 busy  out  1  high from the cycle after an accepted start until done or timeout; done  out  1  one-cycle pulse; timeout  out  1  one-cycle pulse.

Function
REQ-011 States SHALL be IDLE, LOAD, KICK, POLL_REQ, POLL_WAIT and FINISH; all outputs are registered.
REQ-012 IDLE: start=1 SHALL latch base_addr and word_count, then go to LOAD, or to KICK if word_count=0.
REQ-013 LOAD: src_ready=1; each cycle with src_valid=1 SHALL drive write=1, address=base+index, data_out=src_data and byteenable all ones on the next cycle, then increment index.
REQ-014 Address arithmetic SHALL be modulo 2^(WIDTH/2): base_addr+index wraps from 0xFFFF to 0x0000 with no error.
REQ-015 After the word_count-th accepted word, src_ready SHALL drop in the same cycle, so that no extra word is consumed, and the state SHALL go to KICK.
REQ-016 src_valid gaps in LOAD SHALL produce write=0 cycles with no state change.
REQ-017 KICK: one cycle with write_control=1, address_control=0, data_in_control=1; then POLL_REQ.
REQ-018 POLL_REQ: one cycle with read_control=1, address_control=0; then POLL_WAIT.
REQ-019 POLL_WAIT: data_out_control is sampled exactly one cycle after read_control; bit0=1 SHALL go to FINISH, else to POLL_REQ. Each poll therefore takes 2 cycles.
REQ-020 FINISH: done=1 for one cycle, busy=0, return to IDLE; start in the FINISH cycle SHALL be ignored.
REQ-021 start while busy SHALL be ignored with no effect on latched values.
REQ-022 Outside their states, write, write_control, read_control and src_ready SHALL be 0, and address/data outputs SHALL hold their last value.

Reset
REQ-023 reset_sink_reset_n=0 at a clk edge SHALL force IDLE, clear the index and poll counter, and drive busy=done=timeout=write=write_control=read_control=src_ready=0 and address=data_out=data_in_control=0, byteenable=0, address_control=0.
REQ-024 Reset mid-job SHALL abandon the job with no done or timeout pulse; the first start after reset SHALL be honoured.

Configuration
REQ-025 Macro VIDEOCARD_LOADER_TIMEOUT_EN, when defined, SHALL count poll cycles in POLL_REQ/POLL_WAIT and, at TIMEOUT cycles, pulse timeout for one cycle, return to IDLE and never pulse done.
REQ-026 Without VIDEOCARD_LOADER_TIMEOUT_EN, polling SHALL be unbounded, the timeout output SHALL be tied to 0, and no counter is synthesised.

Structure
REQ-027 Package videocard_pkg SHALL hold the state enumeration, CTRL_START_ADDR=0, CTRL_START_VAL=1 and CTRL_DONE_BIT=0.
REQ-028 The block is a single module with no sub-modules; the poll counter is inline.

Verification
REQ-029 start, base_addr=0x0010, word_count=4, src_valid held high -> writes to 0x0010..0x0013 on 4 consecutive cycles, then KICK; readdata bit0=1 on the 3rd poll -> done 1 cycle later, busy low.
REQ-030 base_addr=0xFFFE, word_count=3 -> writes to 0xFFFE, 0xFFFF, 0x0000.
REQ-031 word_count=0 -> zero RAM writes; write_control on the cycle after start; done after the first successful poll.
REQ-032 src_valid toggling 1,0,1,0 with word_count=2 -> exactly 2 writes; src_ready low after the 2nd accept; the 3rd offered word is not consumed.
REQ-033 Macro defined, TIMEOUT=16, bit0 never set -> timeout pulse after 16 poll cycles, done never asserted; macro undefined -> polling continues with timeout=0.
REQ-034 Reset asserted during LOAD after 2 of 8 words -> all outputs at reset values next cycle, no done; a new start then completes normally.

Source files
------------

// File: rtl/videocard_pkg.sv
// Shared definitions for the videocard loader: FSM state encoding and
// control-port register map constants.
package videocard_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        KICK,
        POLL_REQ,
        POLL_WAIT,
        FINISH
    } state_t;

    localparam int unsigned CTRL_START_ADDR = 0;
    localparam int unsigned CTRL_START_VAL  = 1;
    localparam int unsigned CTRL_DONE_BIT   = 0;

endpackage

// File: rtl/videocard_loader_if.sv
// Bus bundle for the videocard loader: source word stream, RAM write port
// and control-port master. The loader uses the master modport.
interface videocard_loader_if #(
    parameter int WIDTH = 32,
    parameter int BYTES = 4
);
    logic [WIDTH-1:0]   src_data;
    logic               src_valid;
    logic               src_ready;

    logic [WIDTH/2-1:0] address;
    logic [WIDTH-1:0]   data_out;
    logic [BYTES-1:0]   byteenable;
    logic               write;

    logic               address_control;
    logic [WIDTH-1:0]   data_in_control;
    logic               write_control;
    logic               read_control;
    logic [WIDTH-1:0]   data_out_control;

    modport master (
        input  src_data, src_valid, data_out_control,
        output src_ready, address, data_out, byteenable, write,
               address_control, data_in_control, write_control, read_control
    );

    modport slave (
        output src_data, src_valid, data_out_control,
        input  src_ready, address, data_out, byteenable, write,
               address_control, data_in_control, write_control, read_control
    );

endinterface

// File: rtl/videocard_loader.sv
// Loads a block of words into video RAM, kicks the card through its control
// port and polls for completion. Optional poll abort: VIDEOCARD_LOADER_TIMEOUT_EN.
module videocard_loader
    import videocard_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic               clk,
    input  logic               reset_sink_reset_n,
    input  logic               start,
    input  logic [WIDTH/2-1:0] base_addr,
    input  logic [WIDTH/2-1:0] word_count,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    videocard_loader_if.master bus
);

    localparam int HALF = WIDTH / 2;

    state_t state, next_state;

    logic [HALF-1:0]  base_q;
    logic [HALF-1:0]  count_q;
    logic [HALF-1:0]  index_q;

    logic             accept;
    logic             last_word;
    logic             poll_ack;
    logic             poll_expired;

    logic             busy_d;
    logic             done_d;
    logic             src_ready_d;
    logic             write_d;
    logic             write_control_d;
    logic             read_control_d;
    logic [HALF-1:0]  address_d;
    logic [WIDTH-1:0] data_out_d;
    logic [BYTES-1:0] byteenable_d;
    logic             address_control_d;
    logic [WIDTH-1:0] data_in_control_d;

    assign accept    = (state == LOAD) && bus.src_valid && bus.src_ready;
    assign last_word = accept && (index_q == count_q - HALF'(1));
    assign poll_ack  = (state == POLL_WAIT) && bus.data_out_control[CTRL_DONE_BIT];

`ifdef VIDEOCARD_LOADER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] poll_cnt;
    logic          polling;

    assign polling      = (state == POLL_REQ) || (state == POLL_WAIT);
    assign poll_expired = polling && (poll_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_sink_reset_n) begin
            poll_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            poll_cnt <= polling ? poll_cnt + CW'(1) : '0;
            timeout  <= poll_expired;
        end
    end
`else
    assign poll_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_sink_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (start) next_state = (word_count == '0) ? KICK : LOAD;
            LOAD:      if (last_word) next_state = KICK;
            KICK:      next_state = POLL_REQ;
            POLL_REQ:  next_state = poll_expired ? IDLE : POLL_WAIT;
            POLL_WAIT: begin
                if (poll_expired)  next_state = IDLE;
                else if (poll_ack) next_state = FINISH;
                else               next_state = POLL_REQ;
            end
            FINISH:    next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so each one lines up with the
    // state it belongs to; RAM writes trail their accept by one cycle.
    always_comb begin
        busy_d            = next_state inside {LOAD, KICK, POLL_REQ, POLL_WAIT};
        done_d            = (next_state == FINISH);
        src_ready_d       = (next_state == LOAD);
        write_control_d   = (next_state == KICK);
        read_control_d    = (next_state == POLL_REQ);
        write_d           = accept;
        address_d         = bus.address;
        data_out_d        = bus.data_out;
        byteenable_d      = bus.byteenable;
        address_control_d = bus.address_control;
        data_in_control_d = bus.data_in_control;

        if (accept) begin
            address_d    = base_q + index_q;
            data_out_d   = bus.src_data;
            byteenable_d = '1;
        end
        if (next_state == KICK) begin
            address_control_d = 1'(CTRL_START_ADDR);
            data_in_control_d = WIDTH'(CTRL_START_VAL);
        end
        if (next_state == POLL_REQ) begin
            address_control_d = 1'(CTRL_START_ADDR);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_sink_reset_n) begin
            busy                <= 1'b0;
            done                <= 1'b0;
            bus.src_ready       <= 1'b0;
            bus.write           <= 1'b0;
            bus.write_control   <= 1'b0;
            bus.read_control    <= 1'b0;
            bus.address         <= '0;
            bus.data_out        <= '0;
            bus.byteenable      <= '0;
            bus.address_control <= 1'b0;
            bus.data_in_control <= '0;
        end else begin
            busy                <= busy_d;
            done                <= done_d;
            bus.src_ready       <= src_ready_d;
            bus.write           <= write_d;
            bus.write_control   <= write_control_d;
            bus.read_control    <= read_control_d;
            bus.address         <= address_d;
            bus.data_out        <= data_out_d;
            bus.byteenable      <= byteenable_d;
            bus.address_control <= address_control_d;
            bus.data_in_control <= data_in_control_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_sink_reset_n) begin
            base_q  <= '0;
            count_q <= '0;
            index_q <= '0;
        end else if ((state == IDLE) && start) begin
            base_q  <= base_addr;
            count_q <= word_count;
            index_q <= '0;
        end else if (accept) begin
            index_q <= index_q + HALF'(1);
        end
    end

endmodule

// File: tb/tb_videocard_loader.sv
// Directed bench for videocard_loader: table of load jobs plus hand-written
// reset, restart, FINISH-start and poll-timeout sequences.
module tb_videocard_loader;

    localparam int WIDTH   = 32;
    localparam int BYTES   = 4;
    localparam int TIMEOUT = 16;
    localparam int MAXC    = 60;

    logic        clk = 1'b0;
    logic        reset_sink_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, timeout;

    videocard_loader_if #(.WIDTH(WIDTH), .BYTES(BYTES)) bus ();

    videocard_loader #(.WIDTH(WIDTH), .BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .reset_sink_reset_n (reset_sink_reset_n),
        .start              (start),
        .base_addr          (base_addr),
        .word_count         (word_count),
        .busy               (busy),
        .done               (done),
        .timeout            (timeout),
        .bus                (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Source stream: each word carries its global sequence number.
    int   taken = 0;
    logic src_valid = 1'b0;
    assign bus.src_valid = src_valid;
    assign bus.src_data  = 32'hC0DE_0000 + 32'(taken);

    always @(posedge clk)
        if (bus.src_valid && bus.src_ready) taken <= taken + 1;

    // Control-port slave: answers only in the cycle after a read, bit0 set
    // once ack_after polls of the current job have been issued.
    int   poll_seen = 0;
    int   poll_base = 0;
    int   ack_after = 0;
    logic rd_prev = 1'b0;
    logic ack_bit;

    always @(posedge clk) begin
        rd_prev <= bus.read_control;
        if (bus.read_control) poll_seen <= poll_seen + 1;
    end
    assign ack_bit = rd_prev && (ack_after != 0) && ((poll_seen - poll_base) >= ack_after);
    assign bus.data_out_control = 32'hA5A5_A5A4 | {31'b0, ack_bit};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ctrl"}, 32'({busy, done, timeout, bus.write, bus.write_control,
                                 bus.read_control, bus.src_ready, bus.address_control,
                                 bus.byteenable}), 32'h0);
        chk({tag, "_address"}, 32'(bus.address), 32'h0);
        chk({tag, "_data_out"}, bus.data_out, 32'h0);
        chk({tag, "_data_in_control"}, bus.data_in_control, 32'h0);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] count;
        int          ack;
        bit          gappy;
        bit          restart;
        logic [15:0] exp_last_addr;
        int          exp_kick;
        int          exp_done;
        int          exp_writes;
    } vec_t;

    // Runs one job from a negedge; returns at the negedge of the done /
    // timeout cycle or after MAXC cycles.
    task automatic run_job(input vec_t v, input string tag,
                           output int kick, output int dn, output int to, output int nw,
                           output logic [15:0] last_addr);
        int t0;
        kick = -1; dn = -1; to = -1; nw = 0; last_addr = '0;
        t0 = taken;
        poll_base = poll_seen;
        ack_after = v.ack;
        start = 1'b1;
        base_addr = v.base;
        word_count = v.count;
        src_valid = !v.gappy;
        for (int k = 1; k <= MAXC; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "_busy_after_start"}, 32'(busy), 32'h1);
            if (bus.write) begin
                chk({tag, "_wr_addr"}, 32'(bus.address), 32'(16'(v.base + 16'(nw))));
                chk({tag, "_wr_data"}, bus.data_out, 32'hC0DE_0000 + 32'(t0 + nw));
                chk({tag, "_wr_be"}, 32'(bus.byteenable), 32'hF);
                last_addr = bus.address;
                nw++;
            end
            if (bus.write_control && kick < 0) begin
                kick = k;
                chk({tag, "_ready_at_kick"}, 32'(bus.src_ready), 32'h0);
                chk({tag, "_kick_value"}, 32'({bus.address_control, bus.data_in_control}), 32'h1);
            end
            if (timeout) begin
                to = k;
                break;
            end
            if (done) begin
                dn = k;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'h0);
                break;
            end
            start = v.restart && (k == 2);
            if (start) begin
                base_addr  = 16'h0500;
                word_count = 16'h0000;
            end
            src_valid = v.gappy ? k[0] : 1'b1;
        end
        start = 1'b0;
        src_valid = 1'b0;
        chk({tag, "_words_consumed"}, 32'(taken - t0), 32'(v.exp_writes));
    endtask

    vec_t vecs[6];
    int kick, dn, to, nw, polls;
    logic [15:0] last_addr;

    initial begin
        vecs[0] = '{16'h0010, 16'd4, 3, 1'b0, 1'b0, 16'h0013,  5, 12, 4};
        vecs[1] = '{16'hFFFE, 16'd3, 1, 1'b0, 1'b0, 16'h0000,  4,  7, 3};
        vecs[2] = '{16'h1234, 16'd0, 1, 1'b0, 1'b0, 16'h0000,  1,  4, 0};
        vecs[3] = '{16'h0040, 16'd2, 1, 1'b1, 1'b0, 16'h0041,  4,  7, 2};
        vecs[4] = '{16'h0200, 16'd3, 2, 1'b0, 1'b1, 16'h0202,  4,  9, 3};
        vecs[5] = '{16'h7FFF, 16'd1, 1, 1'b0, 1'b0, 16'h7FFF,  2,  5, 1};

        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset_sink_reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_job(vecs[i], tag, kick, dn, to, nw, last_addr);
            chk({tag, "_kick_cycle"}, 32'(kick), 32'(vecs[i].exp_kick));
            chk({tag, "_done_cycle"}, 32'(dn), 32'(vecs[i].exp_done));
            chk({tag, "_timeout"}, 32'(to), 32'hFFFF_FFFF);
            chk({tag, "_writes"}, 32'(nw), 32'(vecs[i].exp_writes));
            if (vecs[i].exp_writes > 0)
                chk({tag, "_last_addr"}, 32'(last_addr), 32'(vecs[i].exp_last_addr));
            chk({tag, "_polls"}, 32'(poll_seen - poll_base), 32'(vecs[i].ack));
            chk({tag, "_ctrl_held"}, bus.data_in_control, 32'h1);
            @(negedge clk);
        end

        // start during FINISH must be dropped
        run_job(vecs[5], "fin", kick, dn, to, nw, last_addr);
        chk("fin_done_cycle", 32'(dn), 32'd5);
        start = 1'b1;
        base_addr = 16'h0600;
        word_count = 16'd1;
        @(negedge clk);
        start = 1'b0;
        chk("fin_start_ignored_busy", 32'({busy, bus.src_ready}), 32'h0);
        @(negedge clk);
        chk("fin_start_ignored_kick", 32'({busy, bus.write_control, bus.write}), 32'h0);

        // unanswered polling
        run_job('{16'h0000, 16'd0, 0, 1'b0, 1'b0, 16'h0000, 1, -1, 0},
                "poll", kick, dn, to, nw, last_addr);
        polls = poll_seen - poll_base;
        chk("poll_never_done", 32'(dn), 32'hFFFF_FFFF);
`ifdef VIDEOCARD_LOADER_TIMEOUT_EN
        chk("poll_timeout_cycle", 32'(to), 32'd18);
        chk("poll_busy_at_timeout", 32'(busy), 32'h0);
        chk("poll_count_at_timeout", 32'(polls), 32'd8);
        @(negedge clk);
        chk("poll_timeout_one_cycle", 32'({timeout, done, busy}), 32'h0);
`else
        chk("poll_no_timeout", 32'(to), 32'hFFFF_FFFF);
        chk("poll_still_busy", 32'({busy, timeout}), 32'h2);
        chk("poll_continues", 32'(polls > 16), 32'h1);
`endif

        reset_sink_reset_n = 1'b0;
        @(negedge clk);
        reset_sink_reset_n = 1'b1;
        @(negedge clk);

        // reset in the middle of LOAD after two accepted words
        start = 1'b1;
        base_addr = 16'h0100;
        word_count = 16'd8;
        src_valid = 1'b1;
        nw = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.write) nw++;
        end
        chk("midload_writes_before_reset", 32'(nw), 32'd2);
        reset_sink_reset_n = 1'b0;
        src_valid = 1'b0;
        @(negedge clk);
        chk_reset_values("midload");
        reset_sink_reset_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || timeout || busy) dn++;
        end
        chk("midload_no_resume", 32'(dn), 32'h0);

        run_job('{16'h0300, 16'd2, 1, 1'b0, 1'b0, 16'h0301, 3, 6, 2},
                "after_rst", kick, dn, to, nw, last_addr);
        chk("after_rst_kick", 32'(kick), 32'd3);
        chk("after_rst_done", 32'(dn), 32'd6);
        chk("after_rst_writes", 32'(nw), 32'd2);
        chk("after_rst_last_addr", 32'(last_addr), 32'h0301);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
